// File: rtl/dfu_pkg.sv
// Shared defaults and state encodings for the DFU ping-pong write controller.
package dfu_pkg;

   localparam int DEF_AXI_DATA_WIDTH   = 256;
   localparam int DEF_ES               = 8;
   localparam int DEF_NO_OF_SRAM_BANKS = 32;
   localparam int DEF_SRAM_ADDR        = 10;
   localparam int DEF_TILE_CNT_W       = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_WAIT = 2'd2
   } fsm_state_e;

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_e;

endpackage

// File: rtl/dfu_bank_state.sv
// Per-bank occupancy: set FULL when a tile completes, cleared by the consumer's release.
module dfu_bank_state
   import dfu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic set_full,
   input  logic rel,
   output logic full
);

   bank_state_e st;

   // set_full and rel never coincide on one bank; set wins defensively
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          st <= BANK_EMPTY;
      else if (set_full) st <= BANK_FULL;
      else if (rel)      st <= BANK_EMPTY;
   end

   assign full = (st == BANK_FULL);

endmodule

// File: rtl/dfu_pingpong_wr_ctrl.sv
// Packs AXI read beats into tiles and writes them alternately into SRAM bank A / bank B,
// stalling the stream while the target bank still holds an unreleased tile.
module dfu_pingpong_wr_ctrl
   import dfu_pkg::*;
#(
   parameter int AXI_DATA_WIDTH   = DEF_AXI_DATA_WIDTH,
   parameter int Es               = DEF_ES,
   parameter int no_of_sram_banks = DEF_NO_OF_SRAM_BANKS,
   parameter int sram_addr        = DEF_SRAM_ADDR,
   parameter int TILE_CNT_W       = DEF_TILE_CNT_W
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_start,
   input  logic [sram_addr:0]        cfg_tile_beats,
   input  logic [TILE_CNT_W-1:0]     cfg_num_tiles,
   input  logic                      ar2dfu_data_vld,
   input  logic [AXI_DATA_WIDTH-1:0] ar2dfu_data_in,
   output logic                      dfu2ar_data_rdy,
   input  logic                      ip2dfu_a_release,
   input  logic                      ip2dfu_b_release,
   output logic [AXI_DATA_WIDTH-1:0] wr_data,
   output logic                      wr_a_en,
   output logic                      wr_b_en,
   output logic [sram_addr-1:0]      wr_a_addr,
   output logic [sram_addr-1:0]      wr_b_addr,
   output logic                      bank_a_full,
   output logic                      bank_b_full,
   output logic                      dfu_busy,
   output logic                      dfu_done
);

   fsm_state_e              state;
   logic                    wr_sel;      // 0 = bank A, 1 = bank B
   logic [sram_addr:0]      tile_beats;
   logic [sram_addr:0]      beat_cnt;
   logic [TILE_CNT_W-1:0]   num_tiles;
   logic [TILE_CNT_W-1:0]   tile_cnt;
   logic [1:0]              full;
   logic [1:0]              rel;
   logic [1:0]              rel_eff;
   logic [1:0]              set_full;
   logic                    accept;
   logic                    last_beat;
   logic                    last_tile;
   logic                    other_free;
   logic                    sel_free;
   logic                    cfg_ok;

   assign dfu2ar_data_rdy = (state == ST_FILL);
   assign accept          = ar2dfu_data_vld && dfu2ar_data_rdy;
   assign last_beat       = accept && (beat_cnt == tile_beats - 1'b1);
   assign last_tile       = (tile_cnt == num_tiles - 1'b1);
   assign rel             = {ip2dfu_b_release, ip2dfu_a_release};
   assign cfg_ok          = (cfg_tile_beats != '0) && (cfg_num_tiles != '0);

   // a release landing on the other bank together with our last beat avoids a WAIT bubble
   assign other_free = !full[~wr_sel] || rel[~wr_sel];
   assign sel_free   = !full[wr_sel]  || rel[wr_sel];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign set_full[b] = last_beat && (wr_sel == 1'(b));
      assign rel_eff[b]  = rel[b] && !(dfu2ar_data_rdy && (wr_sel == 1'(b)));

      dfu_bank_state u_bank (
         .clk      (clk),
         .rst      (rst),
         .set_full (set_full[b]),
         .rel      (rel_eff[b]),
         .full     (full[b])
      );
   end

   assign bank_a_full = full[0];
   assign bank_b_full = full[1];

   for (genvar l = 0; l < no_of_sram_banks; l++) begin : g_lane
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)        wr_data[l*Es +: Es] <= '0;
         else if (accept) wr_data[l*Es +: Es] <= ar2dfu_data_in[l*Es +: Es];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         wr_sel     <= 1'b0;
         tile_beats <= '0;
         num_tiles  <= '0;
         beat_cnt   <= '0;
         tile_cnt   <= '0;
         wr_a_en    <= 1'b0;
         wr_b_en    <= 1'b0;
         wr_a_addr  <= '0;
         wr_b_addr  <= '0;
         dfu_busy   <= 1'b0;
         dfu_done   <= 1'b0;
      end else begin
         wr_a_en  <= 1'b0;
         wr_b_en  <= 1'b0;
         dfu_done <= 1'b0;

         if (accept) begin
            if (wr_sel) begin
               wr_b_en   <= 1'b1;
               wr_b_addr <= beat_cnt[sram_addr-1:0];
            end else begin
               wr_a_en   <= 1'b1;
               wr_a_addr <= beat_cnt[sram_addr-1:0];
            end
         end

         case (state)
            ST_IDLE: begin
               if (cfg_start && cfg_ok) begin
                  tile_beats <= cfg_tile_beats;
                  num_tiles  <= cfg_num_tiles;
                  beat_cnt   <= '0;
                  tile_cnt   <= '0;
                  dfu_busy   <= 1'b1;
                  state      <= full[wr_sel] ? ST_WAIT : ST_FILL;
               end
            end
            ST_FILL: begin
               if (accept) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     wr_sel   <= ~wr_sel;
                     tile_cnt <= tile_cnt + 1'b1;
                     if (last_tile) begin
                        state    <= ST_IDLE;
                        dfu_busy <= 1'b0;
                        dfu_done <= 1'b1;
                     end else if (!other_free) begin
                        state <= ST_WAIT;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (sel_free) state <= ST_FILL;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dfu_pingpong_wr_ctrl.sv
// Bench for dfu_pingpong_wr_ctrl: scoreboard of expected bank writes plus directed corner sequences.
module tb_dfu_pingpong_wr_ctrl;

   localparam int DW = 256;
   localparam int AW = 10;
   localparam int TW = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            cfg_start = 1'b0;
   logic [AW:0]     cfg_tile_beats = '0;
   logic [TW-1:0]   cfg_num_tiles = '0;
   logic            ar2dfu_data_vld = 1'b0;
   logic [DW-1:0]   ar2dfu_data_in = '0;
   logic            dfu2ar_data_rdy;
   logic            ip2dfu_a_release = 1'b0;
   logic            ip2dfu_b_release = 1'b0;
   logic [DW-1:0]   wr_data;
   logic            wr_a_en, wr_b_en;
   logic [AW-1:0]   wr_a_addr, wr_b_addr;
   logic            bank_a_full, bank_b_full, dfu_busy, dfu_done;

   dfu_pingpong_wr_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_start        (cfg_start),
      .cfg_tile_beats   (cfg_tile_beats),
      .cfg_num_tiles    (cfg_num_tiles),
      .ar2dfu_data_vld  (ar2dfu_data_vld),
      .ar2dfu_data_in   (ar2dfu_data_in),
      .dfu2ar_data_rdy  (dfu2ar_data_rdy),
      .ip2dfu_a_release (ip2dfu_a_release),
      .ip2dfu_b_release (ip2dfu_b_release),
      .wr_data          (wr_data),
      .wr_a_en          (wr_a_en),
      .wr_b_en          (wr_b_en),
      .wr_a_addr        (wr_a_addr),
      .wr_b_addr        (wr_b_addr),
      .bank_a_full      (bank_a_full),
      .bank_b_full      (bank_b_full),
      .dfu_busy         (dfu_busy),
      .dfu_done         (dfu_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            bank;
      int            addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      int tb;
      int nt;
      bit exp_busy;
   } cfg_vec_t;

   wr_t expq[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   // reference model: job-level view of banks and beats
   bit  m_full [2];
   bit  m_busy;
   bit  m_sel;       // bank receiving the first tile of the current job
   int  m_tb, m_nt, m_acc, m_wr, stall;
   bit  o_wa, o_wb;
   int  o_addr;
   int  n_wr_seen;
   bit  saw_top;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      expq.delete();
      m_full[0] = 0; m_full[1] = 0;
      m_busy = 0; m_sel = 0;
      m_tb = 1; m_nt = 1; m_acc = 0; m_wr = 0; stall = 0;
   endtask

   // Called at a negedge: check rdy, drive one cycle of inputs, then check outputs at next negedge.
   task automatic step(input bit vld, input bit ra, input bit rb, input bit st, input int tb, input int nt);
      logic [DW-1:0] d;
      int            tile;
      bit            tgt;
      bit            exp_done;
      wr_t           w;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
      tile = m_acc / m_tb;
      tgt  = m_sel ^ tile[0];
      if (m_busy && m_acc < m_tb * m_nt) begin
         chk("rdy_into_full_bank", dfu2ar_data_rdy && m_full[tgt], 0);
         stall = (!dfu2ar_data_rdy && !m_full[tgt]) ? stall + 1 : 0;
         chk("stall_on_empty_bank", stall > 1, 0);
      end else begin
         chk("rdy_when_idle", dfu2ar_data_rdy, 0);
      end
      if (vld && dfu2ar_data_rdy) begin
         expq.push_back('{tgt, m_acc % m_tb, d});
         m_acc++;
      end
      ar2dfu_data_vld  = vld;
      ar2dfu_data_in   = d;
      ip2dfu_a_release = ra;
      ip2dfu_b_release = rb;
      cfg_start        = st;
      cfg_tile_beats   = tb[AW:0];
      cfg_num_tiles    = nt[TW-1:0];
      @(posedge clk);
      @(negedge clk);
      cfg_start = 0; ip2dfu_a_release = 0; ip2dfu_b_release = 0; ar2dfu_data_vld = 0;

      if (st && !m_busy && tb != 0 && nt != 0) begin
         m_busy = 1; m_tb = tb; m_nt = nt; m_acc = 0; m_wr = 0; stall = 0;
      end
      if (ra) m_full[0] = 0;
      if (rb) m_full[1] = 0;

      o_wa   = wr_a_en;
      o_wb   = wr_b_en;
      o_addr = wr_a_en ? int'(wr_a_addr) : int'(wr_b_addr);
      chk("both_strobes", wr_a_en && wr_b_en, 0);
      exp_done = 0;
      if (wr_a_en || wr_b_en) begin
         n_wr_seen++;
         if (o_addr == (1 << AW) - 1) saw_top = 1;
         chk("write_expected", expq.size() != 0, 1);
         if (expq.size() != 0) begin
            w = expq.pop_front();
            chk("wr_bank", wr_b_en, w.bank);
            chk("wr_addr", o_addr, w.addr);
            chk_data("wr_data", wr_data, w.data);
            m_wr++;
            if (w.addr == m_tb - 1) m_full[w.bank] = 1;
            if (m_wr == m_tb * m_nt) begin
               exp_done = 1;
               m_busy   = 0;
               m_sel    = m_sel ^ m_nt[0];
            end
         end
      end
      chk("done", dfu_done, exp_done);
      chk("busy", dfu_busy, m_busy);
      chk("bank_a_full", bank_a_full, m_full[0]);
      chk("bank_b_full", bank_b_full, m_full[1]);
   endtask

   task automatic run_rest(input int vld_pct, input int rel_pct, input bit alt, input int poke_at);
      bit v;
      for (int c = 0; c < 5000 && m_busy; c++) begin
         v = alt ? (c % 2 == 0) : ($urandom_range(99) < vld_pct);
         step(v, $urandom_range(99) < rel_pct, $urandom_range(99) < rel_pct, c == poke_at, 3, 1);
      end
      chk("job_finished", m_busy, 0);
   endtask

   task automatic run_job(input int tb, input int nt, input int vld_pct, input int rel_pct,
                          input bit alt, input int poke_at);
      step(0, 0, 0, 1, tb, nt);
      run_rest(vld_pct, rel_pct, alt, poke_at);
   endtask

   task automatic do_reset();
      rst = 0;
      cfg_start = 0; ar2dfu_data_vld = 0; ip2dfu_a_release = 0; ip2dfu_b_release = 0;
      repeat (2) @(negedge clk);
      chk("rst_wr_en", {wr_a_en, wr_b_en}, 0);
      chk("rst_addr", {wr_a_addr, wr_b_addr}, 0);
      chk("rst_data_zero", |wr_data, 0);
      chk("rst_flags", {bank_a_full, bank_b_full, dfu_busy, dfu_done, dfu2ar_data_rdy}, 0);
      rst = 1;
      model_reset();
   endtask

   cfg_vec_t cfg_tab [6];

   initial begin
      cfg_tab[0] = '{0, 2, 0};
      cfg_tab[1] = '{3, 0, 0};
      cfg_tab[2] = '{0, 0, 0};
      cfg_tab[3] = '{1, 1, 1};
      cfg_tab[4] = '{2, 3, 1};
      cfg_tab[5] = '{5, 2, 1};
      n_wr_seen = 0;
      saw_top   = 0;
      model_reset();

      // single 4-beat tile into A
      do_reset();
      step(1, 0, 0, 1, 4, 1);
      chk("t1_wa_before", o_wa, 0);
      for (int k = 0; k < 5; k++) begin
         step(1, 0, 0, 0, 0, 0);
         chk("t1_wa_seq", o_wa, k < 4);
         if (k < 4) chk("t1_addr_seq", o_addr, k);
         chk("t1_done_seq", dfu_done, k == 3);
      end
      chk("t1_full_a", bank_a_full, 1);
      chk("t1_busy", dfu_busy, 0);

      // both banks fill, WAIT, release A resumes into A
      do_reset();
      step(1, 0, 0, 1, 2, 4);
      for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 0);
      chk("t2_wait_rdy", dfu2ar_data_rdy, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("t2_wait_rdy_hold", dfu2ar_data_rdy, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("t2_rdy_after_rel", dfu2ar_data_rdy, 1);
      step(1, 0, 0, 0, 0, 0);
      chk("t2_tile3_wa", o_wa, 1);
      chk("t2_tile3_addr0", o_addr, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("t2_tile3_addr1", o_addr, 1);
      run_rest(100, 30, 0, -1);

      // release A coincident with B's last beat: no bubble
      do_reset();
      step(1, 0, 0, 1, 2, 3);
      for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      chk("t3_no_bubble", dfu2ar_data_rdy, 1);
      step(1, 0, 0, 0, 0, 0);
      chk("t3_wa", o_wa, 1);
      chk("t3_addr0", o_addr, 0);
      run_rest(100, 30, 0, -1);

      // vld alternating
      do_reset();
      n_wr_seen = 0;
      run_job(4, 1, 100, 0, 1, -1);
      chk("t4_write_count", n_wr_seen, 4);

      // full-depth tiles, cfg_start poked mid-job
      do_reset();
      saw_top = 0;
      run_job(1 << AW, 2, 100, 0, 0, 10);
      chk("t5_top_addr", saw_top, 1);

      // async reset mid-tile
      do_reset();
      step(1, 0, 0, 1, 4, 2);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      ar2dfu_data_vld = 1;
      #2 rst = 0;
      #1;
      chk("t6_async_en", {wr_a_en, wr_b_en}, 0);
      chk("t6_async_flags", {bank_a_full, bank_b_full, dfu_busy, dfu_done, dfu2ar_data_rdy}, 0);
      chk("t6_async_addr", {wr_a_addr, wr_b_addr}, 0);
      chk("t6_async_data", |wr_data, 0);
      @(negedge clk);
      chk("t6_held_en", {wr_a_en, wr_b_en}, 0);
      ar2dfu_data_vld = 0;
      rst = 1;
      model_reset();
      step(1, 0, 0, 1, 2, 1);
      step(1, 0, 0, 0, 0, 0);
      chk("t6_restart_wa", o_wa, 1);
      chk("t6_restart_addr", o_addr, 0);
      run_rest(100, 0, 0, -1);

      // randomized jobs back to back, banks carry over between jobs
      do_reset();
      for (int j = 0; j < 14; j++)
         run_job($urandom_range(5, 1), $urandom_range(6, 1), $urandom_range(100, 30),
                 $urandom_range(40, 5), 0, (j % 3 == 0) ? 4 : -1);

      // configuration acceptance table
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 1, cfg_tab[i].tb, cfg_tab[i].nt);
         chk("cfg_accept", dfu_busy, cfg_tab[i].exp_busy);
         run_rest(80, 25, 0, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
